fp16_fma_share_arbiter: RTL and testbench

Shares one pipelined FP16 FMA datapath between NUM_REQ independent requesters. Each requester submits operand triples (a, b, c) over a valid/ready handshake. The block arbitrates round-robin, issues at most one operation per cycle into the FMA and tracks the owner of every in-flight operation with a tag pipeline. It routes each result back to its owner as a one-hot response pulse and sits between the compute lanes and the shared FMA instance.

---
 rtl/fp16_fma_share_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp16_fma_share_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_fma_share_arbiter.sv
// ============================================================================
// fp16_fma_share_arbiter : round-robin sharing of one pipelined FP16 FMA
//   between NUM_REQ requesters, with owner tags travelling alongside the FMA.
//   Optional perf counters are compiled in with `define FMA_ARB_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_fma_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FMA_LATENCY = 4,
  localparam int TAG_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  input  logic [16*NUM_REQ-1:0]  req_c,
  output logic                   fma_in_valid,
  output logic [15:0]            fma_a,
  output logic [15:0]            fma_b,
  output logic [15:0]            fma_c,
  input  logic                   fma_out_valid,
  input  logic [15:0]            fma_out,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   busy,
  output logic                   err
`ifdef FMA_ARB_PERF_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_contend
`endif
);

  localparam logic [TAG_W:0]   NUM_REQ_X = (TAG_W+1)'(NUM_REQ);
  localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(NUM_REQ - 1);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] win;
  logic [TAG_W-1:0] ptr_nxt;
  logic [TAG_W-1:0] issue_tag;
  logic [TAG_W:0]   idx_ext;
  logic             found;
  logic             hs;

  logic [15:0] a_arr [NUM_REQ];
  logic [15:0] b_arr [NUM_REQ];
  logic [15:0] c_arr [NUM_REQ];

  logic [FMA_LATENCY-1:0] stg_vld;
  logic [TAG_W-1:0]       stg_tag [FMA_LATENCY];
  logic                   tail_vld;
  logic [TAG_W-1:0]       tail_tag;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[16*gi +: 16];
      assign b_arr[gi] = req_b[16*gi +: 16];
      assign c_arr[gi] = req_c[16*gi +: 16];
    end
  endgenerate

  // First set req_valid bit at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win     = ptr;
    found   = 1'b0;
    idx_ext = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_ext = {1'b0, ptr} + (TAG_W+1)'(k);
      if (idx_ext >= NUM_REQ_X) begin
        idx_ext = idx_ext - NUM_REQ_X;
      end
      if (!found && req_valid[idx_ext[TAG_W-1:0]]) begin
        win   = idx_ext[TAG_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && enable && !rst) begin
      req_ready[win] = 1'b1;
    end
  end

  assign hs      = |(req_valid & req_ready);
  assign ptr_nxt = (win == LAST_IDX) ? '0 : win + TAG_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      issue_tag    <= '0;
      fma_in_valid <= 1'b0;
      fma_a        <= '0;
      fma_b        <= '0;
      fma_c        <= '0;
    end else begin
      fma_in_valid <= hs;
      if (hs) begin
        ptr       <= ptr_nxt;
        issue_tag <= win;
        fma_a     <= a_arr[win];
        fma_b     <= b_arr[win];
        fma_c     <= c_arr[win];
      end
    end
  end

  // The FMA never stalls, so the tag pipe shifts unconditionally and its
  // last stage lines up with fma_out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FMA_LATENCY; k++) begin
        stg_vld[k] <= 1'b0;
        stg_tag[k] <= '0;
      end
    end else begin
      stg_vld[0] <= fma_in_valid;
      stg_tag[0] <= issue_tag;
      for (int k = 1; k < FMA_LATENCY; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_tag[k] <= stg_tag[k-1];
      end
    end
  end

  assign tail_vld = stg_vld[FMA_LATENCY-1];
  assign tail_tag = stg_tag[FMA_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (fma_out_valid && tail_vld) begin
        rsp_valid <= NUM_REQ'(1) << tail_tag;
        rsp_data  <= fma_out;
      end
      if (fma_out_valid != tail_vld) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = (|stg_vld) | fma_in_valid | (|rsp_valid);

`ifdef FMA_ARB_PERF_EN
  logic multi_req;
  assign multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_stall   <= '0;
      perf_contend <= '0;
    end else begin
      if (hs && perf_issued != '1) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if ((|req_valid) && !hs && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (multi_req && perf_contend != '1) begin
        perf_contend <= perf_contend + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp16_fma_share_arbiter.sv
// ============================================================================
// tb_fp16_fma_share_arbiter : scoreboard bench with a behavioural FMA stand-in
//   and a round-robin reference model. Perf checks need FMA_ARB_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp16_fma_share_arbiter;

  localparam int N = 4;
  localparam int L = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [16*N-1:0]  req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]     req_ready;
  logic             fma_in_valid;
  logic [15:0]      fma_a, fma_b, fma_c;
  logic             fma_out_valid;
  logic [15:0]      fma_out;
  logic [N-1:0]     rsp_valid;
  logic [15:0]      rsp_data;
  logic             busy, err;
`ifdef FMA_ARB_PERF_EN
  logic [31:0]      perf_issued, perf_stall, perf_contend;
`endif

  fp16_fma_share_arbiter #(.NUM_REQ(N), .FMA_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fma_in_valid(fma_in_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_out_valid(fma_out_valid), .fma_out(fma_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err(err)
`ifdef FMA_ARB_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_contend(perf_contend)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Arbitrary deterministic mixing function standing in for the FMA arithmetic.
  function automatic logic [15:0] fake_fma(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
    logic [15:0] r;
    r = (a * 16'd3) ^ {b[7:0], b[15:8]} ^ (c + 16'h1357);
    return r;
  endfunction

  logic        sh_v [L];
  logic [15:0] sh_d [L];
  logic        force_v = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        sh_v[k] <= 1'b0;
        sh_d[k] <= '0;
      end
    end else begin
      sh_v[0] <= fma_in_valid;
      sh_d[0] <= fake_fma(fma_a, fma_b, fma_c);
      for (int k = 1; k < L; k++) begin
        sh_v[k] <= sh_v[k-1];
        sh_d[k] <= sh_d[k-1];
      end
    end
  end

  assign fma_out_valid = sh_v[L-1] | force_v;
  assign fma_out       = sh_d[L-1];

  typedef struct { logic [47:0] ops; int cyc; } iss_t;
  typedef struct { logic [N-1:0] who; logic [15:0] data; int cyc; } rsp_t;
  iss_t iq[$];
  rsp_t rq[$];
  iss_t e_iss;
  rsp_t e_rsp;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (fma_in_valid) begin
      if (iq.size() == 0) begin
        chk("issue_unexpected", {63'd0, fma_in_valid}, 64'd0);
      end else begin
        e_iss = iq.pop_front();
        chk("issue_ops", {fma_a, fma_b, fma_c}, e_iss.ops);
        chk("issue_cycle", cyc, e_iss.cyc);
      end
    end
    if (rsp_valid != '0) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, '0);
      end else begin
        e_rsp = rq.pop_front();
        chk("rsp_owner", rsp_valid, e_rsp.who);
        chk("rsp_data", rsp_data, e_rsp.data);
        chk("rsp_cycle", cyc, e_rsp.cyc);
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic en,
                      input logic [16*N-1:0] a, input logic [16*N-1:0] b,
                      input logic [16*N-1:0] c);
    logic [N-1:0] exp_rdy;
    int w;
    @(negedge clk);
    rst = 1'b0; req_valid = v; enable = en;
    req_a = a; req_b = b; req_c = c;
    #1;
    exp_rdy = '0;
    w = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (w >= 0) begin
      iq.push_back('{ops: {a[16*w +: 16], b[16*w +: 16], c[16*w +: 16]}, cyc: cyc + 1});
      rq.push_back('{who: exp_rdy,
                     data: fake_fma(a[16*w +: 16], b[16*w +: 16], c[16*w +: 16]),
                     cyc: cyc + L + 2});
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic step_rand(input logic [N-1:0] v, input logic en);
    logic [16*N-1:0] a, b, c;
    for (int i = 0; i < N; i++) begin
      a[16*i +: 16] = 16'($urandom);
      b[16*i +: 16] = 16'($urandom);
      c[16*i +: 16] = 16'($urandom);
    end
    step(v, en, a, b, c);
  endtask

  task automatic drain();
    bit had;
    bit done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      had = (iq.size() + rq.size()) != 0;
      step_rand('0, 1'b1);
      if (iq.size() == 0 && rq.size() == 0) begin
        if (had) chk("busy_last_rsp", busy, 1);
        done = 1'b1;
      end
    end
    chk("drain_timeout", iq.size() + rq.size(), 0);
    step_rand('0, 1'b1);
    chk("busy_idle", busy, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = '1; enable = 1'b1;
    iq.delete(); rq.delete(); m_ptr = 0;
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_fma_in_valid", fma_in_valid, 0);
    chk("rst_fma_ops", {fma_a, fma_b, fma_c}, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*N-1:0] a, b, c;
    do_reset(3);

    // All four requesters contend for eight cycles straight out of reset.
    repeat (8) step_rand('1, 1'b1);
    step_rand('0, 1'b1);
`ifdef FMA_ARB_PERF_EN
    chk("perf_issued", perf_issued, 8);
    chk("perf_contend", perf_contend, 8);
    chk("perf_stall", perf_stall, 0);
`endif
    drain();

    a = '0; b = '0; c = '0;
    a[32 +: 16] = 16'h3C00; b[32 +: 16] = 16'h4000; c[32 +: 16] = 16'h3C00;
    step(4'b0100, 1'b1, a, b, c);
    drain();

    repeat (5) step_rand(4'b0010, 1'b1);
    drain();

    repeat (3) step_rand('1, 1'b1);
    repeat (6) step_rand('1, 1'b0);
    drain();

    for (int i = 0; i < 100; i++) begin
      step_rand(N'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset two cycles after three issues: nothing may come back.
    repeat (3) step_rand('1, 1'b1);
    repeat (2) step_rand('0, 1'b1);
    do_reset(2);
    repeat (8) step_rand('0, 1'b1);
    step_rand('1, 1'b1);
    drain();

    // Spurious FMA result with an empty tag pipe.
    @(negedge clk);
    req_valid = '0; force_v = 1'b1;
    @(negedge clk);
    force_v = 1'b0;
    #1;
    chk("err_set", err, 1);
    chk("err_no_rsp", rsp_valid, '0);
    repeat (4) step_rand('0, 1'b1);
    chk("err_sticky", err, 1);
    chk("pending_at_end", iq.size() + rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
